down_counter_timer: RTL and testbench

//  Loadable down-counter/timer; the counting-down complement of the team's Counter4R up-counter.
//  - A producer hands it a start value over a valid/ready load handshake.
//  - It decrements on each enabled cycle and raises a one-cycle ZERO pulse at terminal count.
//  - Sits beside the up-counters as the timeout/terminal-count source for control FSMs.

---
 rtl/down_counter_timer.sv | 97 +++++++++
 tb/tb_down_counter_timer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counter/timer with one-cycle terminal-count pulse
// Optional feature: define DOWN_COUNTER_TIMER_AUTORELOAD_EN to restart from the loaded value at terminal count.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Gated with rst_n so no producer sees a ready while the block is held in reset.
  assign load_ready = rst_n & (state == IDLE) & ~clear;

`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else if (load_ready && load_valid) begin
      reload_q <= load_val;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o     <= '0;
      zero  <= 1'b0;
      busy  <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      o     <= '0;
      zero  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      zero <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            o    <= load_val;
            busy <= 1'b1;
            if (load_val != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              zero  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (en) begin
            if (o > WIDTH'(1)) begin
              o <= o - WIDTH'(1);
            end else begin
              // Terminal event: o is 1 here, the FSM never lets it reach 0 in RUN.
              zero <= 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
              o    <= reload_q;
`else
              o     <= '0;
              state <= DONE;
`endif
            end
          end
        end
        DONE: begin
          o     <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          o     <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - scoreboard bench for down_counter_timer
// Define DOWN_COUNTER_TIMER_AUTORELOAD_EN for both files to exercise the auto-reload build.
module tb_down_counter_timer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] o;
  logic             busy;
  logic             zero;

  int checks = 0;
  int errors = 0;

  // Expected {o, zero, busy} after each driven edge.
  logic [WIDTH+1:0] exp_q[$];

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_val   (load_val),
    .en         (en),
    .clear      (clear),
    .o          (o),
    .busy       (busy),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational ready, queue the post-edge expectation.
  task automatic step(input logic lv, input logic [WIDTH-1:0] lval, input logic e, input logic c,
                      input logic exp_rdy, input logic [WIDTH-1:0] eo, input logic ez, input logic eb);
    @(negedge clk);
    load_valid = lv;
    load_val   = lval;
    en         = e;
    clear      = c;
    #1;
    check("load_ready", {31'd0, load_ready}, {31'd0, exp_rdy});
    exp_q.push_back({eo, ez, eb});
  endtask

  always @(posedge clk) begin
    logic [WIDTH+1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("o",    {28'd0, o},    {28'd0, e[WIDTH+1:2]});
      check("zero", {31'd0, zero}, {31'd0, e[1]});
      check("busy", {31'd0, busy}, {31'd0, e[0]});
    end
  end

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_val   = '0;
    en         = 1'b0;
    clear      = 1'b0;
    #2;
    check("rst_o",    {28'd0, o},          0);
    check("rst_zero", {31'd0, zero},       0);
    check("rst_busy", {31'd0, busy},       0);
    check("rst_rdy",  {31'd0, load_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-count at o=3
    step(1, 4'd5, 1, 0, 1, 4'd5, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd4, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd3, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_o",    {28'd0, o},          0);
    check("midrst_zero", {31'd0, zero},       0);
    check("midrst_busy", {31'd0, busy},       0);
    check("midrst_rdy",  {31'd0, load_ready}, 0);
    #2;
    rst_n = 1'b1;
    step(0, 4'd0, 1, 0, 1, 4'd0, 0, 0);
    step(0, 4'd0, 1, 0, 1, 4'd0, 0, 0);

`ifndef DOWN_COUNTER_TIMER_AUTORELOAD_EN
    // Load 5, en held high
    step(1, 4'd5, 1, 0, 1, 4'd5, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd4, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd3, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd2, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd1, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd0, 1, 1);
    step(0, 4'd0, 1, 0, 0, 4'd0, 0, 0);
    step(0, 4'd0, 1, 0, 1, 4'd0, 0, 0);

    // Load 3, en toggled 1,0,1,0,1
    step(1, 4'd3, 0, 0, 1, 4'd3, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd2, 0, 1);
    step(0, 4'd0, 0, 0, 0, 4'd2, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd1, 0, 1);
    step(0, 4'd0, 0, 0, 0, 4'd1, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd0, 1, 1);
    step(0, 4'd0, 0, 0, 0, 4'd0, 0, 0);

    // Max value 15 with en high: pulse 15 cycles after accept
    step(1, 4'd15, 1, 0, 1, 4'd15, 0, 1);
    for (int i = 14; i >= 1; i--) step(0, 4'd0, 1, 0, 0, 4'(i), 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd0, 1, 1);
    step(0, 4'd0, 1, 0, 0, 4'd0, 0, 0);
`else
    // Auto-reload: load 15, two full periods
    step(1, 4'd15, 1, 0, 1, 4'd15, 0, 1);
    for (int p = 0; p < 2; p++) begin
      for (int i = 14; i >= 1; i--) step(0, 4'd0, 1, 0, 0, 4'(i), 0, 1);
      step(0, 4'd0, 1, 0, 0, 4'd15, 1, 1);
    end
    step(0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
    // Load 1: terminal event every enabled cycle
    step(1, 4'd1, 1, 0, 1, 4'd1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 4'd0, 1, 0, 0, 4'd1, 1, 1);
    step(0, 4'd0, 0, 0, 0, 4'd1, 0, 1);
    step(0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
`endif

    // Load 0: DONE with pulse, load during DONE refused
    step(1, 4'd0, 0, 0, 1, 4'd0, 1, 1);
    step(1, 4'd7, 0, 0, 0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0, 1, 4'd0, 0, 0);

    // Load during RUN refused, then clear at o==1 with en high
    step(1, 4'd2, 0, 0, 1, 4'd2, 0, 1);
    step(1, 4'd9, 0, 0, 0, 4'd2, 0, 1);
    step(0, 4'd0, 1, 0, 0, 4'd1, 0, 1);
    step(0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
    step(0, 4'd0, 1, 0, 1, 4'd0, 0, 0);
    // Clear with load_valid in IDLE: no load
    step(1, 4'd6, 1, 1, 0, 4'd0, 0, 0);
    step(0, 4'd0, 1, 0, 1, 4'd0, 0, 0);

    @(negedge clk);
    load_valid = 1'b0;
    en         = 1'b0;
    @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
